// File: rtl/pcie_msi_irq_gen_pkg.sv
// Shared types and helpers for the MSI interrupt generator.
package pcie_msi_irq_gen_pkg;

  localparam int MSI_W = 32;
  localparam int PTR_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } msi_state_e;

  // MMEnable grants 2^n vectors; encodings above 5 are treated as 32 vectors.
  function automatic logic [MSI_W-1:0] range_mask(input logic [2:0] mme);
    logic [MSI_W-1:0] m;
    case (mme)
      3'd0:    m = 32'h0000_0001;
      3'd1:    m = 32'h0000_0003;
      3'd2:    m = 32'h0000_000F;
      3'd3:    m = 32'h0000_00FF;
      3'd4:    m = 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

  function automatic logic [MSI_W-1:0] count_mask(input int cnt);
    logic [MSI_W-1:0] m;
    m = '0;
    for (int i = 0; i < MSI_W; i++) begin
      if (i < cnt) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pcie_msi_irq_gen_rr_arbiter.sv
// Round-robin picker: first request at or above ptr, wrapping modulo N.
module msi_rr_arbiter
  import pcie_msi_irq_gen_pkg::*;
#(
  parameter int N = MSI_W
) (
  input  logic [MSI_W-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [MSI_W-1:0] grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             grant_vld
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!grant_vld && req[(int'(ptr) + i) % N]) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'((int'(ptr) + i) % N);
      end
    end
    if (grant_vld) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/pcie_msi_irq_gen.sv
// Edge-latched per-vector interrupts issued as MSI requests to the PCIe hard IP.
module pcie_msi_irq_gen
  import pcie_msi_irq_gen_pkg::*;
#(
  parameter int MSI_COUNT = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MSI_COUNT-1:0] msi_irq,
  input  logic [3:0]           cfg_interrupt_msi_enable,
  input  logic [7:0]           cfg_interrupt_msi_vf_enable,
  input  logic [11:0]          cfg_interrupt_msi_mmenable,
  input  logic                 cfg_interrupt_msi_mask_update,
  input  logic [31:0]          cfg_interrupt_msi_data,
  output logic [3:0]           cfg_interrupt_msi_select,
  output logic [31:0]          cfg_interrupt_msi_int,
  output logic [31:0]          cfg_interrupt_msi_pending_status,
  output logic                 cfg_interrupt_msi_pending_status_data_enable,
  output logic [3:0]           cfg_interrupt_msi_pending_status_function_num,
  input  logic                 cfg_interrupt_msi_sent,
  input  logic                 cfg_interrupt_msi_fail,
  output logic [2:0]           cfg_interrupt_msi_attr,
  output logic                 cfg_interrupt_msi_tph_present,
  output logic [1:0]           cfg_interrupt_msi_tph_type,
  output logic [8:0]           cfg_interrupt_msi_tph_st_tag,
  output logic [3:0]           cfg_interrupt_msi_function_number
);

  localparam logic [MSI_W-1:0] VEC_MASK = count_mask(MSI_COUNT);

  msi_state_e       state_q, state_d;
  logic [MSI_W-1:0] irq_prev_q, irq_prev_d;
  logic [MSI_W-1:0] pending_q, pending_d;
  logic [MSI_W-1:0] int_q, int_d;
  logic [MSI_W-1:0] pstat_q, pstat_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] idx_q, idx_d;

  logic [MSI_W-1:0] irq_v, rise, eligible, grant;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_vld;
  logic             retire;
  logic             unused_cfg;

  assign irq_v    = MSI_W'(msi_irq);
  assign rise     = irq_v & ~irq_prev_q & VEC_MASK;
  assign eligible = pending_q & ~cfg_interrupt_msi_data & VEC_MASK
                  & range_mask(cfg_interrupt_msi_mmenable[2:0])
                  & {MSI_W{cfg_interrupt_msi_enable[0]}};
  // A fail wins over a simultaneous sent, so the vector is retried.
  assign retire   = (state_q == WAIT) && cfg_interrupt_msi_sent && !cfg_interrupt_msi_fail;

  msi_rr_arbiter #(.N(MSI_COUNT)) u_arb (
    .req       (eligible),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      irq_prev_q <= '0;
      pending_q  <= '0;
      int_q      <= '0;
      pstat_q    <= '0;
      rr_ptr_q   <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      irq_prev_q <= irq_prev_d;
      pending_q  <= pending_d;
      int_q      <= int_d;
      pstat_q    <= pstat_d;
      rr_ptr_q   <= rr_ptr_d;
      idx_q      <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld) state_d = WAIT;
      WAIT:    if (cfg_interrupt_msi_sent || cfg_interrupt_msi_fail) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    irq_prev_d = irq_v;
    int_d      = '0;
    idx_d      = idx_q;
    rr_ptr_d   = rr_ptr_q;
    pending_d  = pending_q;
    if (state_q == IDLE && grant_vld) begin
      int_d = grant;
      idx_d = grant_idx;
    end
    if (retire) begin
      pending_d[idx_q] = 1'b0;
      rr_ptr_d = (idx_q == PTR_W'(MSI_COUNT - 1)) ? '0 : idx_q + 5'd1;
    end
    // A new edge in the retire cycle re-arms the same vector.
    pending_d = pending_d | rise;
    pstat_d   = pending_q & cfg_interrupt_msi_data & VEC_MASK;
  end

  assign cfg_interrupt_msi_int                          = int_q;
  assign cfg_interrupt_msi_pending_status               = pstat_q;
  assign cfg_interrupt_msi_select                       = '0;
  assign cfg_interrupt_msi_pending_status_data_enable   = 1'b0;
  assign cfg_interrupt_msi_pending_status_function_num  = '0;
  assign cfg_interrupt_msi_attr                         = '0;
  assign cfg_interrupt_msi_tph_present                  = 1'b0;
  assign cfg_interrupt_msi_tph_type                     = '0;
  assign cfg_interrupt_msi_tph_st_tag                   = '0;
  assign cfg_interrupt_msi_function_number              = '0;

  assign unused_cfg = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_vf_enable,
                        cfg_interrupt_msi_mmenable[11:3], cfg_interrupt_msi_mask_update};

endmodule

// File: tb/tb_pcie_msi_irq_gen.sv
// Directed and randomized checks of pcie_msi_irq_gen against a behavioural model.
module tb_pcie_msi_irq_gen;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq;
  logic [3:0]    en;
  logic [7:0]    vf_en;
  logic [11:0]   mme;
  logic          mask_upd;
  logic [31:0]   data;
  logic [3:0]    sel;
  logic [31:0]   dut_int;
  logic [31:0]   dut_ps;
  logic          ps_de;
  logic [3:0]    ps_fn;
  logic          sent;
  logic          fail;
  logic [2:0]    attr;
  logic          tph_p;
  logic [1:0]    tph_t;
  logic [8:0]    tph_st;
  logic [3:0]    fn;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  bit [31:0] m_pend, m_prev, m_int, m_ps;
  int        m_rr, m_cur;
  bit        m_busy;

  always #5 clk = ~clk;

  pcie_msi_irq_gen #(.MSI_COUNT(N)) dut (
    .clk                                           (clk),
    .rst                                           (rst),
    .msi_irq                                       (irq),
    .cfg_interrupt_msi_enable                      (en),
    .cfg_interrupt_msi_vf_enable                   (vf_en),
    .cfg_interrupt_msi_mmenable                    (mme),
    .cfg_interrupt_msi_mask_update                 (mask_upd),
    .cfg_interrupt_msi_data                        (data),
    .cfg_interrupt_msi_select                      (sel),
    .cfg_interrupt_msi_int                         (dut_int),
    .cfg_interrupt_msi_pending_status              (dut_ps),
    .cfg_interrupt_msi_pending_status_data_enable  (ps_de),
    .cfg_interrupt_msi_pending_status_function_num (ps_fn),
    .cfg_interrupt_msi_sent                        (sent),
    .cfg_interrupt_msi_fail                        (fail),
    .cfg_interrupt_msi_attr                        (attr),
    .cfg_interrupt_msi_tph_present                 (tph_p),
    .cfg_interrupt_msi_tph_type                    (tph_t),
    .cfg_interrupt_msi_tph_st_tag                  (tph_st),
    .cfg_interrupt_msi_function_number             (fn)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_consts();
    chk("select", 32'(sel), 32'd0);
    chk("ps_data_en", 32'(ps_de), 32'd0);
    chk("ps_func", 32'(ps_fn), 32'd0);
    chk("attr_tph", {18'd0, attr, tph_p, tph_t, tph_st}, 32'd0);
    chk("func_num", 32'(fn), 32'd0);
  endtask

  // One clock: update the model from the inputs present at the edge, then compare.
  task automatic step();
    bit [31:0] nint, nps, npend;
    int lim, k;
    @(posedge clk);
    if (rst) begin
      m_pend = '0; m_prev = '0; m_rr = 0; m_busy = 0;
      nint = '0; nps = '0;
    end else begin
      nps   = m_pend & data;
      nint  = '0;
      npend = m_pend;
      if (m_busy) begin
        if (fail) m_busy = 0;
        else if (sent) begin
          npend[m_cur] = 1'b0;
          m_rr   = (m_cur + 1) % N;
          m_busy = 0;
        end
      end else if (en[0]) begin
        lim = 1 << ((mme[2:0] > 3'd5) ? 5 : int'(mme[2:0]));
        for (int i = 0; i < N; i++) begin
          k = (m_rr + i) % N;
          if (m_pend[k] && !data[k] && k < lim) begin
            nint   = 32'd1 << k;
            m_cur  = k;
            m_busy = 1;
            break;
          end
        end
      end
      npend  = npend | (irq & ~m_prev);
      m_prev = irq;
      m_pend = npend;
    end
    m_int = nint;
    m_ps  = nps;
    @(negedge clk);
    chk("int", dut_int, m_int);
    chk("pstat", dut_ps, m_ps);
  endtask

  task automatic respond(input bit s, input bit f);
    sent = s; fail = f;
    step();
    sent = 0; fail = 0;
  endtask

  task automatic do_reset();
    rst = 1; step(); step(); rst = 0;
  endtask

  initial begin
    rst = 1; irq = '0; en = 4'h1; vf_en = '0; mme = 12'd5; mask_upd = 0;
    data = '0; sent = 0; fail = 0;
    @(negedge clk);
    do_reset();
    chk("rst_int", dut_int, 32'd0);
    chk("rst_ps", dut_ps, 32'd0);
    chk_consts();

    // Single vector, accepted
    irq = 32'h8; step(); irq = '0; step();
    chk("t1_int", dut_int, 32'h8);
    step();
    chk("t1_int_one_cycle", dut_int, 32'h0);
    respond(1, 0);
    repeat (4) step();
    chk("t1_no_repeat", dut_int, 32'h0);
    chk("t1_ps", dut_ps, 32'h0);

    // Round robin 0 then 5, then wrap back to 0
    do_reset();
    irq = 32'h21; step(); irq = '0; step();
    chk("t2_first", dut_int, 32'h1);
    step(); respond(1, 0); step();
    chk("t2_second", dut_int, 32'h20);
    step(); respond(1, 0);
    irq = 32'h1; step(); irq = '0; step();
    chk("t2_wrap", dut_int, 32'h1);
    step(); respond(1, 0);

    // Masked vector held pending
    data = 32'h4; irq = 32'h4; step(); irq = '0; step();
    chk("t3_masked_int", dut_int, 32'h0);
    chk("t3_ps", dut_ps, 32'h4);
    data = '0; step();
    chk("t3_unmasked", dut_int, 32'h4);
    step(); respond(1, 0);

    // Out-of-range vector waits for a larger MMEnable
    mme = 12'd1; irq = 32'h80; step(); irq = '0; step(); step();
    chk("t4_out_of_range", dut_int, 32'h0);
    mme = 12'd5; step();
    chk("t4_in_range", dut_int, 32'h80);
    step(); respond(1, 0);

    // Fail then retry
    irq = 32'h2; step(); irq = '0; step();
    chk("t5_first", dut_int, 32'h2);
    step(); respond(0, 1); step();
    chk("t5_retry", dut_int, 32'h2);
    step(); respond(1, 1); step();
    chk("t5_both_is_fail", dut_int, 32'h2);
    step(); respond(1, 0); repeat (3) step();
    chk("t5_cleared", dut_int, 32'h0);

    // Disabled, then reset while waiting
    en = 4'h0; irq = 32'h10; step(); irq = '0; step(); step();
    chk("t6_disabled", dut_int, 32'h0);
    en = 4'h1; step();
    chk("t6_enabled", dut_int, 32'h10);
    step();
    rst = 1; step();
    chk("t6_rst_int", dut_int, 32'h0);
    chk("t6_rst_ps", dut_ps, 32'h0);
    rst = 0; repeat (3) step();
    chk("t6_dropped", dut_int, 32'h0);

    // Irq held through reset registers an edge on the first cycle out
    irq = 32'h200; rst = 1; step(); rst = 0; step(); step();
    chk("t7_held_edge", dut_int, 32'h200);
    step(); respond(1, 0); irq = '0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      irq = irq ^ ($urandom() & $urandom() & $urandom());
      if ($urandom_range(0, 40) == 0) data = ($urandom_range(0, 1) != 0) ? ($urandom() & $urandom()) : '0;
      if ($urandom_range(0, 60) == 0) mme = 12'($urandom_range(0, 7));
      if ($urandom_range(0, 80) == 0) en = ($urandom_range(0, 3) != 0) ? 4'h1 : 4'he;
      rst = ($urandom_range(0, 400) == 0);
      sent = 0; fail = 0;
      if (m_busy) begin
        case ($urandom_range(0, 9))
          0, 1, 2: sent = 1;
          3:       fail = 1;
          4:       begin sent = 1; fail = 1; end
          default: ;
        endcase
      end
      step();
    end
    rst = 0; sent = 0; fail = 0;
    step();
    chk_consts();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
